// File: rtl/fpu_issue_pkg.sv
// Shared types for the FMA issue controller.
// FSM state, queue entry layout and the timeout exception code.
package fpu_issue_pkg;
  localparam int FPWID = 80;
  localparam int TAGW  = 5;
  localparam int XW    = 8;
  localparam int OPW   = FPWID + 4;
  localparam int IW    = 40;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic [IW-1:0]   instr;
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [OPW-1:0]  c;
  } issue_ent_t;

  localparam logic [XW-1:0] EXC_TMO = '1;
endpackage

// File: rtl/fpu_issue_if.sv
// Dispatch, FMA-unit and writeback signals of the issue controller.
// master = controller side, slave = surrounding pipeline.
interface fpu_issue_if;
  import fpu_issue_pkg::*;

  logic            iss_v;
  logic            iss_rdy;
  logic [IW-1:0]   iss_instr;
  logic [2:0]      iss_rm;
  logic [TAGW-1:0] iss_tag;
  logic [OPW-1:0]  iss_a;
  logic [OPW-1:0]  iss_b;
  logic [OPW-1:0]  iss_c;

  logic            fu_ld;
  logic            fu_v;
  logic [IW-1:0]   fu_instr;
  logic [2:0]      fu_rm;
  logic [TAGW-1:0] fu_tag;
  logic [OPW-1:0]  fu_a;
  logic [OPW-1:0]  fu_b;
  logic [OPW-1:0]  fu_c;
  logic            fu_idle;
  logic            fu_v_o;
  logic [TAGW-1:0] fu_tag_o;
  logic [OPW-1:0]  fu_o;
  logic [XW-1:0]   fu_exc;

  logic            wb_v;
  logic            wb_rdy;
  logic [TAGW-1:0] wb_tag;
  logic [OPW-1:0]  wb_o;
  logic [XW-1:0]   wb_exc;

  logic            busy;
  logic            err_tag;
  logic            err_tmo;

  modport master (
    input  iss_v, iss_instr, iss_rm, iss_tag,
    input  iss_a, iss_b, iss_c,
    input  fu_idle, fu_v_o, fu_tag_o, fu_o, fu_exc,
    input  wb_rdy,
    output iss_rdy,
    output fu_ld, fu_v, fu_instr, fu_rm, fu_tag,
    output fu_a, fu_b, fu_c,
    output wb_v, wb_tag, wb_o, wb_exc,
    output busy, err_tag, err_tmo
  );

  modport slave (
    output iss_v, iss_instr, iss_rm, iss_tag,
    output iss_a, iss_b, iss_c,
    output fu_idle, fu_v_o, fu_tag_o, fu_o, fu_exc,
    output wb_rdy,
    input  iss_rdy,
    input  fu_ld, fu_v, fu_instr, fu_rm, fu_tag,
    input  fu_a, fu_b, fu_c,
    input  wb_v, wb_tag, wb_o, wb_exc,
    input  busy, err_tag, err_tmo
  );
endinterface

// File: rtl/fpu_issue_fifo.sv
// In-order issue queue; extra pointer bit
// disambiguates full from empty on wrap.
import fpu_issue_pkg::*;

module fpu_issue_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  issue_ent_t i_ent,
  output issue_ent_t o_head,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(QDEPTH);

  issue_ent_t     r_mem [QDEPTH];
  logic [AW:0]    r_wp;
  logic [AW:0]    r_rp;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head  = r_mem[r_rp[AW-1:0]];

  // pointer update on push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + (AW+1)'(1);
      if (i_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  // entry storage, written at the write pointer
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_ent;
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the pipelined FMA unit: queues ops,
// launches one at a time, returns results to writeback.
import fpu_issue_pkg::*;

module fpu_issue_ctrl #(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  fpu_issue_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [TAGW-1:0] r_tag;
  logic            r_wb_v;
  logic [TAGW-1:0] r_wb_tag;
  logic [OPW-1:0]  r_wb_o;
  logic [XW-1:0]   r_wb_exc;
  logic            r_err_tag;
  logic            r_err_tmo;

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_go;
  issue_ent_t w_in;
  issue_ent_t w_head;

  assign w_in = '{
    instr: bus.iss_instr,
    rm:    bus.iss_rm,
    tag:   bus.iss_tag,
    a:     bus.iss_a,
    b:     bus.iss_b,
    c:     bus.iss_c
  };

  assign w_push = bus.iss_v & ~w_full;
  assign w_pop  = (r_state == S_LAUNCH) & ce;
  assign w_go   = ~w_empty & bus.fu_idle;

  fpu_issue_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_ent  (w_in),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign bus.iss_rdy  = ~w_full;
  assign bus.fu_ld    = w_pop;
  assign bus.fu_v     = w_pop;
  assign bus.fu_instr = w_head.instr;
  assign bus.fu_rm    = w_head.rm;
  assign bus.fu_tag   = w_head.tag;
  assign bus.fu_a     = w_head.a;
  assign bus.fu_b     = w_head.b;
  assign bus.fu_c     = w_head.c;
  assign bus.wb_v     = r_wb_v;
  assign bus.wb_tag   = r_wb_tag;
  assign bus.wb_o     = r_wb_o;
  assign bus.wb_exc   = r_wb_exc;
  assign bus.busy     = ~w_empty | (r_state != S_IDLE);
  assign bus.err_tag  = r_err_tag;
  assign bus.err_tmo  = r_err_tmo;

  // launch/wait/hold sequencing; wb handshake ignores ce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tag     <= '0;
      r_wb_v    <= 1'b0;
      r_wb_tag  <= '0;
      r_wb_o    <= '0;
      r_wb_exc  <= '0;
      r_err_tag <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      if (ce) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_go) r_state <= S_LAUNCH;
          end
          S_LAUNCH: begin
            r_tag   <= w_head.tag;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_cnt <= r_cnt + CW'(1);
            if (bus.fu_v_o) begin
              r_wb_v   <= 1'b1;
              r_wb_tag <= bus.fu_tag_o;
              r_wb_o   <= bus.fu_o;
              r_wb_exc <= bus.fu_exc;
              if (bus.fu_tag_o != r_tag) r_err_tag <= 1'b1;
              r_state <= S_HOLD;
            end else if (r_cnt == CW'(TIMEOUT-1)) begin
              r_wb_v    <= 1'b1;
              r_wb_tag  <= r_tag;
              r_wb_o    <= '0;
              r_wb_exc  <= EXC_TMO;
              r_err_tmo <= 1'b1;
              r_state   <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bus.wb_rdy || !r_wb_v)
              r_state <= w_go ? S_LAUNCH : S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (r_state == S_HOLD && bus.wb_rdy) r_wb_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: single op, back-pressure,
// wb stall, tag mismatch, timeout, reset in WAIT.
import fpu_issue_pkg::*;

module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  fpu_issue_if bus ();

  fpu_issue_ctrl #(.QDEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .bus(bus)
  );

  int ntests = 0;
  int nfail  = 0;
  int nld    = 0;
  int nld0;
  logic [OPW-1:0] big;

  always @(negedge clk) if (bus.fu_ld) nld++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch_one(input logic [TAGW-1:0] t);
    bus.iss_v   = 1'b1;
    bus.iss_tag = t;
    bus.iss_a   = OPW'(t) + OPW'(16'h1000);
    bus.fu_idle = 1'b1;
    tick;
    bus.iss_v = 1'b0;
    tick;
    chk("lnch_ld", bus.fu_ld, 1);
    chk("lnch_tag", bus.fu_tag, t);
    bus.fu_idle = 1'b0;
    tick;
  endtask

  task automatic serve(input logic [TAGW-1:0] t, input bit more,
                       input logic [TAGW-1:0] nt);
    bus.fu_v_o   = 1'b1;
    bus.fu_tag_o = t;
    bus.fu_o     = OPW'(t) ^ OPW'(12'h5A5);
    bus.fu_exc   = '0;
    tick;
    bus.fu_v_o = 1'b0;
    chk("srv_wbv", bus.wb_v, 1);
    chk("srv_wbtag", bus.wb_tag, t);
    chk("srv_wbo", bus.wb_o, OPW'(t) ^ OPW'(12'h5A5));
    bus.wb_rdy  = 1'b1;
    bus.fu_idle = 1'b1;
    tick;
    bus.wb_rdy  = 1'b0;
    bus.fu_idle = 1'b0;
    chk("srv_wbv0", bus.wb_v, 0);
    if (more) begin
      chk("srv_ld", bus.fu_ld, 1);
      chk("srv_ntag", bus.fu_tag, nt);
      tick;
    end else begin
      chk("srv_idle", bus.busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    bus.iss_v     = 1'b0;
    bus.iss_instr = '0;
    bus.iss_rm    = '0;
    bus.iss_tag   = '0;
    bus.iss_a     = '0;
    bus.iss_b     = '0;
    bus.iss_c     = '0;
    bus.fu_idle   = 1'b0;
    bus.fu_v_o    = 1'b0;
    bus.fu_tag_o  = '0;
    bus.fu_o      = '0;
    bus.fu_exc    = '0;
    bus.wb_rdy    = 1'b0;
    big = {20'h3FFF8, 64'h0};
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_wbv", bus.wb_v, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_etag", bus.err_tag, 0);
    chk("rst_etmo", bus.err_tmo, 0);
    chk("rst_rdy", bus.iss_rdy, 1);
    chk("rst_ld", bus.fu_ld, 0);
    chk("rst_wbtag", bus.wb_tag, 0);
    chk("rst_wbo", bus.wb_o, 0);
    chk("rst_wbexc", bus.wb_exc, 0);

    // single op
    nld0 = nld;
    bus.iss_v     = 1'b1;
    bus.iss_tag   = 5'd3;
    bus.iss_instr = 40'h12_3456_789A;
    bus.iss_rm    = 3'd2;
    bus.iss_a     = 84'h1234;
    bus.iss_b     = 84'h5678;
    bus.iss_c     = 84'h9ABC;
    bus.fu_idle   = 1'b1;
    tick;
    bus.iss_v = 1'b0;
    chk("so_busy", bus.busy, 1);
    chk("so_ld0", bus.fu_ld, 0);
    tick;
    chk("so_ld", bus.fu_ld, 1);
    chk("so_v", bus.fu_v, 1);
    chk("so_tag", bus.fu_tag, 3);
    chk("so_instr", bus.fu_instr, 40'h12_3456_789A);
    chk("so_rm", bus.fu_rm, 2);
    chk("so_a", bus.fu_a, 84'h1234);
    chk("so_c", bus.fu_c, 84'h9ABC);
    bus.fu_idle = 1'b0;
    tick;
    chk("so_ld1", bus.fu_ld, 0);
    repeat (26) tick;
    bus.fu_v_o   = 1'b1;
    bus.fu_tag_o = 5'd3;
    bus.fu_o     = big;
    bus.fu_exc   = 8'h01;
    tick;
    bus.fu_v_o = 1'b0;
    chk("so_wbv", bus.wb_v, 1);
    chk("so_wbtag", bus.wb_tag, 3);
    chk("so_wbo", bus.wb_o, big);
    chk("so_wbexc", bus.wb_exc, 8'h01);
    chk("so_etag", bus.err_tag, 0);
    chk("so_nld", nld - nld0, 1);
    bus.wb_rdy = 1'b1;
    tick;
    bus.wb_rdy = 1'b0;
    chk("so_wbv0", bus.wb_v, 0);
    chk("so_busy0", bus.busy, 0);

    // back-pressure, launch order 0..4
    bus.iss_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.iss_tag = 5'(i);
      tick;
      if (i == 2) chk("bp_rdy3", bus.iss_rdy, 1);
    end
    chk("bp_full", bus.iss_rdy, 0);
    bus.iss_tag = 5'd4;
    tick;
    chk("bp_refuse", bus.iss_rdy, 0);
    bus.fu_idle = 1'b1;
    tick;
    chk("bp_ld", bus.fu_ld, 1);
    chk("bp_tag0", bus.fu_tag, 0);
    chk("bp_rdyL", bus.iss_rdy, 0);
    bus.fu_idle = 1'b0;
    tick;
    chk("bp_rdyfree", bus.iss_rdy, 1);
    tick;
    bus.iss_v = 1'b0;
    chk("bp_refull", bus.iss_rdy, 0);
    serve(5'd0, 1'b1, 5'd1);
    serve(5'd1, 1'b1, 5'd2);
    serve(5'd2, 1'b1, 5'd3);
    serve(5'd3, 1'b1, 5'd4);
    serve(5'd4, 1'b0, 5'd0);

    // wb stall with a queued op behind it
    bus.fu_idle = 1'b1;
    bus.iss_v   = 1'b1;
    bus.iss_tag = 5'd7;
    tick;
    bus.iss_tag = 5'd8;
    tick;
    bus.iss_v = 1'b0;
    chk("st_ld", bus.fu_ld, 1);
    chk("st_tag", bus.fu_tag, 7);
    bus.fu_idle = 1'b0;
    tick;
    bus.fu_v_o   = 1'b1;
    bus.fu_tag_o = 5'd7;
    bus.fu_o     = 84'hABC;
    tick;
    bus.fu_v_o  = 1'b0;
    bus.fu_idle = 1'b1;
    nld0 = nld;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("st_wbv", bus.wb_v, 1);
      chk("st_wbo", bus.wb_o, 84'hABC);
      chk("st_wbtag", bus.wb_tag, 7);
    end
    chk("st_nold", nld - nld0, 0);
    bus.wb_rdy = 1'b1;
    tick;
    bus.wb_rdy = 1'b0;
    chk("st_ld2", bus.fu_ld, 1);
    chk("st_tag2", bus.fu_tag, 8);
    chk("st_wbv0", bus.wb_v, 0);
    bus.fu_idle = 1'b0;
    tick;
    serve(5'd8, 1'b0, 5'd0);

    // tag mismatch
    launch_one(5'd5);
    bus.fu_v_o   = 1'b1;
    bus.fu_tag_o = 5'd6;
    tick;
    bus.fu_v_o = 1'b0;
    chk("tm_etag", bus.err_tag, 1);
    chk("tm_wbtag", bus.wb_tag, 6);
    chk("tm_wbv", bus.wb_v, 1);
    bus.wb_rdy = 1'b1;
    tick;
    bus.wb_rdy = 1'b0;
    chk("tm_busy", bus.busy, 0);
    chk("tm_sticky", bus.err_tag, 1);

    // timeout, then wb handshake with ce low
    launch_one(5'd9);
    repeat (63) tick;
    chk("to_pre", bus.err_tmo, 0);
    chk("to_prewb", bus.wb_v, 0);
    tick;
    chk("to_etmo", bus.err_tmo, 1);
    chk("to_wbv", bus.wb_v, 1);
    chk("to_exc", bus.wb_exc, 8'hFF);
    chk("to_tag", bus.wb_tag, 9);
    chk("to_o", bus.wb_o, 0);
    ce = 1'b0;
    bus.wb_rdy = 1'b1;
    tick;
    bus.wb_rdy = 1'b0;
    chk("ce_wbv0", bus.wb_v, 0);
    chk("ce_hold", bus.busy, 1);
    ce = 1'b1;
    tick;
    chk("ce_idle", bus.busy, 0);

    // reset while waiting, with a queued op
    launch_one(5'd10);
    bus.iss_v   = 1'b1;
    bus.iss_tag = 5'd11;
    tick;
    bus.iss_v = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.fu_v_o   = 1'b1;
    bus.fu_tag_o = 5'd10;
    tick;
    bus.fu_v_o = 1'b0;
    chk("rw_wbv", bus.wb_v, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_rdy", bus.iss_rdy, 1);
    chk("rw_etag", bus.err_tag, 0);
    chk("rw_etmo", bus.err_tmo, 0);
    tick;
    chk("rw_ld", bus.fu_ld, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
